// File: rtl/cpu_defs.sv
// Shared register-file definitions for decode and writeback.
// No logic. Holds only constants and types, so there is no latency and no backpressure.
package cpu_defs;
    localparam int REG_ADDR_W = 3;
    localparam int NUM_REGS   = 8;
    localparam int DATA_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/Mux_8to1.sv
// Single-bit 8:1 select that picks one bit out of eight.
// Latency is zero (combinational). There is no backpressure.
module Mux_8to1
    import cpu_defs::*;
(
    input  logic [7:0] d,
    input  reg_addr_t  sel,
    output logic       y
);
    assign y = d[sel];
endmodule

// File: rtl/cpu_reg_read_port.sv
// One register-file read port: a bit-sliced 8:1 select plus a write-through bypass.
// Latency is zero (combinational). There is no backpressure.
module cpu_reg_read_port
    import cpu_defs::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
    input  reg_addr_t                      rd_addr,
    input  logic                           wr_en,
    input  reg_addr_t                      wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [WIDTH-1:0]               rd_data
);
    logic [WIDTH-1:0] mux_out;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        logic [7:0] slice;

        always_comb begin
            slice = '0;
            for (int j = 0; j < NUM_REGS; j++) begin
                slice[j] = regs[j][k];
            end
        end

        Mux_8to1 u_mux (
            .d   (slice),
            .sel (rd_addr),
            .y   (mux_out[k])
        );
    end

    // A retiring write is visible in the same cycle it is presented.
    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mux_out;
endmodule

// File: rtl/cpu_reg_file.sv
// 8-entry register file with two bypassed combinational reads, one write port and a busy scoreboard.
// Reads have 0-cycle latency. Writes and scoreboard updates land on the next rising clk edge. There is no backpressure.
module cpu_reg_file
    import cpu_defs::*;
#(
    parameter int               WIDTH     = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  reg_addr_t         wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  reg_addr_t         rd_addr_a,
    input  reg_addr_t         rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              iss_en,
    input  reg_addr_t         iss_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [7:0]        busy_vec
);
    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [NUM_REGS-1:0]            busy_nxt;
    logic                           wr_act;

    // The bypass is masked during reset so that reads return RESET_VAL while rst is high.
    assign wr_act = wr_en & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A set is applied after the clear, so a new issue wins over a retiring write to the same register.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_nxt;
        end
    end

    assign busy_a = busy_vec[rd_addr_a] & ~(wr_act & (wr_addr == rd_addr_a));
    assign busy_b = busy_vec[rd_addr_b] & ~(wr_act & (wr_addr == rd_addr_b));

    cpu_reg_read_port #(.WIDTH(WIDTH)) u_port_a (
        .regs    (regs),
        .rd_addr (rd_addr_a),
        .wr_en   (wr_act),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a)
    );

    cpu_reg_read_port #(.WIDTH(WIDTH)) u_port_b (
        .regs    (regs),
        .rd_addr (rd_addr_b),
        .wr_en   (wr_act),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b)
    );
endmodule

// File: tb/tb_cpu_reg_file.sv
// Bench for cpu_reg_file: directed cases plus randomized traffic checked against an array model.
module tb_cpu_reg_file;
    import cpu_defs::*;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    reg_addr_t   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    reg_addr_t   rd_addr_a = '0;
    reg_addr_t   rd_addr_b = '0;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;
    logic        iss_en = 1'b0;
    reg_addr_t   iss_addr = '0;
    logic        busy_a;
    logic        busy_b;
    logic [7:0]  busy_vec;

    logic [W-1:0] mreg  [8];
    bit           mbusy [8];
    int           n_err = 0;
    int           n_chk = 0;

    cpu_reg_file #(.WIDTH(W), .RESET_VAL('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_vec  (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input reg_addr_t a);
        if (wr_en && wr_addr == a) return wr_data;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input reg_addr_t a);
        return mbusy[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [7:0] exp_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mbusy[i];
        return v;
    endfunction

    // Called 1 time unit after a rising edge; checks combinational outputs, then advances one cycle.
    task automatic step();
        #3;
        chk("rd_a",   rd_data_a, exp_rd(rd_addr_a));
        chk("rd_b",   rd_data_b, exp_rd(rd_addr_b));
        chk("busy_a", busy_a,    exp_busy(rd_addr_a));
        chk("busy_b", busy_b,    exp_busy(rd_addr_b));
        chk("vec",    busy_vec,  exp_vec());
        @(posedge clk);
        if (wr_en) begin
            mreg[wr_addr]  = wr_data;
            mbusy[wr_addr] = 1'b0;
        end
        if (iss_en) mbusy[iss_addr] = 1'b1;
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        iss_en = 1'b0;
    endtask

    task automatic rand_cycles(input int n);
        reg_addr_t a;
        for (int c = 0; c < n; c++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = reg_addr_t'($urandom_range(0, 7));
            wr_data   = W'($urandom);
            rd_addr_a = reg_addr_t'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : reg_addr_t'($urandom_range(0, 7));
            a         = reg_addr_t'($urandom_range(0, 7));
            iss_addr  = a;
            iss_en    = ($urandom_range(0, 2) != 0) && (!mbusy[a] || (wr_en && wr_addr == a));
            step();
        end
        idle();
    endtask

    initial begin
        model_clear();
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_vec", busy_vec, 8'h00);
        chk("reset_rd_a", rd_data_a, 16'h0000);

        // Write R3, then read it back next cycle.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        step();
        idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd4;
        #1;
        chk("wr_r3", rd_data_a, 16'hBEEF);
        chk("rd_r4", rd_data_b, 16'h0000);
        #(-1 + 1);
        step();

        // Both ports see a same-cycle write through the bypass.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        #1;
        chk("byp_a", rd_data_a, 16'h1234);
        chk("byp_b", rd_data_b, 16'h1234);
        step();

        // Issue R2, then retire it.
        idle(); iss_en = 1'b1; iss_addr = 3'd2; rd_addr_a = 3'd2;
        step();
        idle();
        #1;
        chk("iss_vec", busy_vec, 8'h04);
        chk("iss_busy_a", busy_a, 1'b1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA;
        #1;
        chk("retire_busy_a", busy_a, 1'b0);
        chk("retire_vec_pre", busy_vec, 8'h04);
        step();
        idle();
        chk("retire_vec", busy_vec, 8'h00);
        chk("retire_data", rd_data_a, 16'h00AA);

        // Set/clear collision on R6.
        iss_en = 1'b1; iss_addr = 3'd6;
        step();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h5A5A; iss_en = 1'b1; iss_addr = 3'd6;
        step();
        idle(); rd_addr_b = 3'd6;
        #1;
        chk("coll_vec6", busy_vec[6], 1'b1);
        chk("coll_data", rd_data_b, 16'h5A5A);
        chk("coll_busy_b", busy_b, 1'b1);
        step();

        rand_cycles(10000);

        // Asynchronous reset mid-cycle while a write and issue are in flight.
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h7777; iss_en = 1'b1; iss_addr = 3'd1;
        step();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hFFFF; iss_en = 1'b1; iss_addr = 3'd3;
        rd_addr_a = 3'd2; rd_addr_b = 3'd1;
        #1;
        chk("pre_rst_busy_b", busy_b, 1'b1);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("rst_rd_a", rd_data_a, 16'h0000);
        chk("rst_rd_b", rd_data_b, 16'h0000);
        chk("rst_busy_b", busy_b, 1'b0);
        chk("rst_vec", busy_vec, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = reg_addr_t'(i);
            rd_addr_b = reg_addr_t'(7 - i);
            #1;
            chk("rst_scan_a", rd_data_a, 16'h0000);
            chk("rst_scan_b", rd_data_b, 16'h0000);
        end
        chk("rst_scan_vec", busy_vec, 8'h00);
        @(posedge clk);
        #1;

        rand_cycles(500);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
